vga_sync_generator: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/pixel_tick_gen.sv | 38 +++
 rtl/vga_sync_generator.sv | 126 ++++++++++++
 tb/tb_vga_sync_generator.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | vga_timing_pkg : 640x480@60 VGA timing constants and counter helpers      |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package vga_timing_pkg;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Both syncs are asserted low for this mode.
  localparam logic SYNC_ACTIVE = 1'b0;

  function automatic logic in_window(input cnt_t v, input cnt_t lo, input cnt_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_tick_gen.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pixel_tick_gen : registered one-cycle enable pulse every DIV clocks       |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module pixel_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk_100MHz,
  input  logic reset,
  output logic pixel_tick
);

  localparam int DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pixel_tick_q, pixel_tick_d;

  always_comb begin
    div_cnt_d    = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    pixel_tick_d = (div_cnt_q == DIV_LAST);
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      div_cnt_q    <= '0;
      pixel_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      pixel_tick_q <= pixel_tick_d;
    end
  end

  assign pixel_tick = pixel_tick_q;

endmodule
`default_nettype wire

// File: rtl/vga_sync_generator.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | vga_sync_generator : 640x480@60 H/V counters, syncs and visible flag      |
// | Optional macro VGA_FRAME_COUNTER_EN adds an 8-bit frame_count output.     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module vga_sync_generator
  import vga_timing_pkg::*;
#(
  parameter int DIV       = 4,
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  output logic             pixel_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start
`ifdef VGA_FRAME_COUNTER_EN
  ,
  output logic [7:0]       frame_count
`endif
);

  localparam cnt_t H_LAST   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam cnt_t H_VIS    = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS    = cnt_t'(V_VISIBLE);
  localparam cnt_t HS_START = cnt_t'(H_VISIBLE + H_FRONT);
  localparam cnt_t HS_END   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam cnt_t VS_START = cnt_t'(V_VISIBLE + V_FRONT);
  localparam cnt_t VS_END   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC);

  logic tick;

  pixel_tick_gen #(
    .DIV (DIV)
  ) u_pixel_tick_gen (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .pixel_tick (tick)
  );

  cnt_t pixel_x_q, pixel_x_d;
  cnt_t pixel_y_q, pixel_y_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic video_on_q, video_on_d;
  logic frame_start_q, frame_start_d;

  // Decode from the next counter values so every registered output lines up
  // with the coordinates it is reported alongside.
  always_comb begin
    pixel_x_d = pixel_x_q;
    pixel_y_d = pixel_y_q;
    if (tick) begin
      if (pixel_x_q == H_LAST) begin
        pixel_x_d = '0;
        pixel_y_d = (pixel_y_q == V_LAST) ? '0 : pixel_y_q + cnt_t'(1);
      end else begin
        pixel_x_d = pixel_x_q + cnt_t'(1);
      end
    end
    hsync_d       = in_window(pixel_x_d, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d       = in_window(pixel_y_d, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    video_on_d    = (pixel_x_d < H_VIS) && (pixel_y_d < V_VIS);
    frame_start_d = tick && (pixel_x_q == H_LAST) && (pixel_y_q == V_LAST);
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      video_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_tick  = tick;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign frame_start = frame_start_q;

`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] frame_count_q, frame_count_d;

  // Advances on the same edge frame_start rises, so it names the frame now starting.
  always_comb begin
    frame_count_d = frame_start_d ? frame_count_q + 8'd1 : frame_count_q;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      frame_count_q <= 8'd0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_generator.sv
`default_nettype none
// Testbench for vga_sync_generator: full-size timing instance plus a tiny-timing
// instance for frame wrap, mid-frame reset and frame counter behaviour.
module tb_vga_sync_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       tick_a, hs_a, vs_a, von_a, fs_a;
  logic       tick_b, hs_b, vs_b, von_b, fs_b;
  logic [9:0] x_a, y_a, x_b, y_b;
`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] fc_a, fc_b;
`endif

  vga_sync_generator dut_a (
    .clk_100MHz (clk),
    .reset      (rst_a),
    .pixel_tick (tick_a),
    .hsync      (hs_a),
    .vsync      (vs_a),
    .video_on   (von_a),
    .pixel_x    (x_a),
    .pixel_y    (y_a),
    .frame_start(fs_a)
`ifdef VGA_FRAME_COUNTER_EN
    ,
    .frame_count(fc_a)
`endif
  );

  // Tiny mode: DIV 2, H total 8 (hsync low x in [5,6]), V total 5 (vsync low y = 3)
  vga_sync_generator #(
    .DIV(2), .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_b (
    .clk_100MHz (clk),
    .reset      (rst_b),
    .pixel_tick (tick_b),
    .hsync      (hs_b),
    .vsync      (vs_b),
    .video_on   (von_b),
    .pixel_x    (x_b),
    .pixel_y    (y_b),
    .frame_start(fs_b)
`ifdef VGA_FRAME_COUNTER_EN
    ,
    .frame_count(fc_b)
`endif
  );

  typedef struct {
    int         k;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       tick;
  } vec_t;

  vec_t vecs [14];

  int checks = 0;
  int errors = 0;
  int ka = 0, kb = 0;
  int tick_cnt_a = 0, gap_err_a = 0, last_tick_a = 0;
  int hs_low_a = 0, vs_low_a = 0, fs_cnt_a = 0;
  int fs_cnt_b = 0, vs_low_b = 0;
  bit vs_b_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ka++;
    kb++;
    if (!rst_a) begin
      if (tick_a) begin
        if (ka <= 10000) tick_cnt_a++;
        if (last_tick_a != 0 && (ka - last_tick_a) != 4) gap_err_a++;
        last_tick_a = ka;
      end
      if (!hs_a && ka <= 3200) hs_low_a++;
      if (!vs_a) vs_low_a++;
      if (fs_a) fs_cnt_a++;
    end
    if (fs_b) fs_cnt_b++;
    if (vs_b_en && !vs_b) vs_low_b++;
  endtask

  task automatic chk_b(input string tag, input int x, input int y, input int hs,
                       input int vs, input int von, input int fs);
    chk({tag, "_x"}, int'(x_b), x);
    chk({tag, "_y"}, int'(y_b), y);
    chk({tag, "_hs"}, int'(hs_b), hs);
    chk({tag, "_vs"}, int'(vs_b), vs);
    chk({tag, "_von"}, int'(von_b), von);
    chk({tag, "_fs"}, int'(fs_b), fs);
  endtask

  initial begin
    // k = clock edges after reset release; pixel count p = (k-1)/DIV
    vecs[0]  = '{0,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{3,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{4,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{5,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{8,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{2557, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{2561, 10'd640, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{2621, 10'd655, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{2625, 10'd656, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3005, 10'd751, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3009, 10'd752, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{3197, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{3201, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{3205, 10'd1,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) step();
    chk("rst_fs_a", int'(fs_a), 0);
    rst_a = 1'b0;
    ka = 0;

    for (int i = 0; i < 14; i++) begin
      while (ka < vecs[i].k) step();
      chk($sformatf("x_a@%0d", ka),    int'(x_a),    int'(vecs[i].x));
      chk($sformatf("y_a@%0d", ka),    int'(y_a),    int'(vecs[i].y));
      chk($sformatf("hs_a@%0d", ka),   int'(hs_a),   int'(vecs[i].hs));
      chk($sformatf("vs_a@%0d", ka),   int'(vs_a),   int'(vecs[i].vs));
      chk($sformatf("von_a@%0d", ka),  int'(von_a),  int'(vecs[i].von));
      chk($sformatf("tick_a@%0d", ka), int'(tick_a), int'(vecs[i].tick));
    end
    while (ka < 10000) step();
    chk("tick_count_10k", tick_cnt_a, 2500);
    chk("tick_gap_errors", gap_err_a, 0);
    chk("hsync_low_line0", hs_low_a, 384);
    chk("vsync_low_lines0_3", vs_low_a, 0);
    chk("frame_start_a_none", fs_cnt_a, 0);

    // Tiny instance: first frame and wrap (40 pixels = 80 clocks)
    rst_a = 1'b1;
    chk_b("b_rst", 0, 0, 1, 1, 1, 0);
    rst_b = 1'b0;
    kb = 0;
    fs_cnt_b = 0;
    vs_b_en = 1;
    while (kb < 59) step();
    chk_b("b_k59", 5, 3, 0, 0, 0, 0);
    while (kb < 80) step();
    vs_b_en = 0;
    chk_b("b_k80", 7, 4, 1, 1, 0, 0);
    chk("b_fs_before_wrap", fs_cnt_b, 0);
    chk("b_vsync_low_clocks", vs_low_b, 16);
    step();
    chk_b("b_k81", 0, 0, 1, 1, 1, 1);
    step();
    chk("b_fs_width", int'(fs_b), 0);
    chk("b_fs_count", fs_cnt_b, 1);

    // Mid-frame reset at (5,3) of the second frame
    while (kb < 139) step();
    chk_b("b_k139", 5, 3, 0, 0, 0, 0);
    rst_b = 1'b1;
    fs_cnt_b = 0;
    step();
    chk_b("b_midrst", 0, 0, 1, 1, 1, 0);
    chk("b_midrst_tick", int'(tick_b), 0);
`ifdef VGA_FRAME_COUNTER_EN
    chk("b_midrst_fc", int'(fc_b), 0);
`endif
    rst_b = 1'b0;
    kb = 0;
    step();
    chk("b_re_k1_tick", int'(tick_b), 0);
    chk("b_re_k1_x", int'(x_b), 0);
    step();
    chk("b_re_k2_tick", int'(tick_b), 1);
    chk("b_re_k2_x", int'(x_b), 0);
    step();
    chk("b_re_k3_tick", int'(tick_b), 0);
    chk("b_re_k3_x", int'(x_b), 1);
    chk("b_re_no_fs", fs_cnt_b, 0);

`ifdef VGA_FRAME_COUNTER_EN
    begin
      int n = 0;
      int budget = 257 * 80 + 200;
      while (n < 257 && budget > 0) begin
        step();
        budget--;
        if (fs_b) begin
          n++;
          chk($sformatf("fc_frame%0d", n), int'(fc_b), n % 256);
        end
      end
      chk("fc_frames_seen", n, 257);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
